// File: rtl/spi_tx_feeder.sv
// -----------------------------------------------------------------------------
// spi_tx_feeder
//
// Feeds 7-bit frames from a small transmit FIFO to a downstream SPI master
// using a send/done handshake. A byte is latched onto data_in and send is
// raised. The byte is popped, and frames_sent is incremented, when the master
// reports done. The next frame may start only after done has fallen again.
//
// Optional feature (compile-time macro SPI_GAP_EN):
//   When SPI_GAP_EN is defined, a GAP state enforces GAP_CYCLES idle cycles
//   after done falls and before the next frame can start. When it is
//   undefined, RELEASE returns straight to IDLE.
//
// Parameters:
//   DEPTH       FIFO depth in 7-bit entries (power of two, 2..16)
//   GAP_CYCLES  idle cycles between frames when SPI_GAP_EN is defined (1..255)
//
// Ports:
//   clk          in   1      sole clock, rising-edge
//   rst          in   1      synchronous, active-high reset
//   wr_data      in   7      byte to transmit
//   wr_valid     in   1      wr_data is valid
//   wr_ready     out  1      FIFO can accept (write = wr_valid & wr_ready)
//   data_in      out  7      frame data to the SPI master
//   send         out  1      start-frame request to the SPI master
//   done         in   1      frame-complete from the SPI master
//   busy         out  1      FIFO non-empty or frame in progress
//   fifo_count   out  CW     FIFO entries currently held
//   frames_sent  out  8      completed-frame counter (wraps 255 -> 0)
// -----------------------------------------------------------------------------
module spi_tx_feeder #(
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [6:0]               wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  output logic [6:0]               data_in,
  output logic                     send,
  input  logic                     done,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [7:0]               frames_sent
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT  = CW'(DEPTH);
  localparam logic [CW-1:0] EMPTY_COUNT = CW'(0);
  localparam logic [CW-1:0] ONE_COUNT   = CW'(1);
  localparam logic [AW-1:0] ZERO_PTR    = AW'(0);
  localparam logic [AW-1:0] ONE_PTR     = AW'(1);

  // Reject illegal configurations at elaboration time.
  if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0) ||
      (GAP_CYCLES < 1) || (GAP_CYCLES > 255)) begin : g_bad_param
    $error("spi_tx_feeder: DEPTH must be a power of two in 2..16 and GAP_CYCLES in 1..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2,
    ST_GAP     = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [6:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_next_s;

  // Handshake and FSM state
  state_t        state_r;
  logic          send_r;
  logic [6:0]    data_r;
  logic [7:0]    frames_r;
`ifdef SPI_GAP_EN
  logic [7:0]    gap_cnt_r;
`endif

  logic          wr_ready_s;
  logic          push_s;
  logic          pop_s;

  // Full flag is derived purely from the registered count, so wr_ready never
  // depends on same-cycle inputs.
  assign wr_ready_s = (count_r != FULL_COUNT);

  // A write happens on a valid/ready handshake; the head is popped on the
  // single cycle in which REQ observes done.
  always_comb begin
    push_s = 1'b0;
    pop_s  = 1'b0;
    if (wr_valid && wr_ready_s) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    if ((state_r == ST_REQ) && done) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Next FIFO occupancy; a simultaneous push and pop cancel out.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + ONE_COUNT;
      2'b01:   count_next_s = count_r - ONE_COUNT;
      default: count_next_s = count_r;
    endcase
  end

  // FIFO data array write port. Reset blocks a coincident write.
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // FIFO pointers and occupancy counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= ZERO_PTR;
      rd_ptr_r <= ZERO_PTR;
      count_r  <= EMPTY_COUNT;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + ONE_PTR;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_PTR;
      end
      count_r <= count_next_s;
    end
  end

  // Frame sequencer: IDLE -> REQ -> RELEASE [-> GAP] -> IDLE.
  // data_in is only loaded when leaving IDLE, so it stays stable for the
  // whole of REQ. A done that is still high in IDLE blocks a new frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      send_r    <= 1'b0;
      data_r    <= 7'd0;
      frames_r  <= 8'd0;
`ifdef SPI_GAP_EN
      gap_cnt_r <= 8'd0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if ((count_r != EMPTY_COUNT) && !done) begin
            data_r  <= mem_r[rd_ptr_r];
            send_r  <= 1'b1;
            state_r <= ST_REQ;
          end else begin
            send_r  <= 1'b0;
          end
        end
        ST_REQ: begin
          if (done) begin
            // frames_sent wraps naturally from 255 to 0.
            frames_r <= frames_r + 8'd1;
            send_r   <= 1'b0;
            state_r  <= ST_RELEASE;
          end else begin
            send_r   <= 1'b1;
          end
        end
        ST_RELEASE: begin
          send_r <= 1'b0;
          if (!done) begin
`ifdef SPI_GAP_EN
            gap_cnt_r <= 8'(GAP_CYCLES);
            state_r   <= ST_GAP;
`else
            state_r   <= ST_IDLE;
`endif
          end
        end
        ST_GAP: begin
          send_r <= 1'b0;
`ifdef SPI_GAP_EN
          // One cycle per count; leave once the counter reaches zero.
          if (gap_cnt_r <= 8'd1) begin
            gap_cnt_r <= 8'd0;
            state_r   <= ST_IDLE;
          end else begin
            gap_cnt_r <= gap_cnt_r - 8'd1;
          end
`else
          // Unreachable without the gap feature; recover to IDLE.
          state_r <= ST_IDLE;
`endif
        end
        default: begin
          send_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign wr_ready    = wr_ready_s;
  assign data_in     = data_r;
  assign send        = send_r;
  assign fifo_count  = count_r;
  assign frames_sent = frames_r;
  assign busy        = (count_r != EMPTY_COUNT) | (state_r != ST_IDLE);

endmodule

// File: tb/tb_spi_tx_feeder.sv
// -----------------------------------------------------------------------------
// tb_spi_tx_feeder
//
// Directed testbench for spi_tx_feeder (DEPTH=4, GAP_CYCLES=2). Inputs are
// driven 1 ns after each rising edge, and outputs are sampled at that same
// point, away from the active edge. Expected gap timing follows SPI_GAP_EN.
// -----------------------------------------------------------------------------
module tb_spi_tx_feeder;

  localparam int DEPTH      = 4;
  localparam int GAP_CYCLES = 2;
`ifdef SPI_GAP_EN
  localparam int EXP_GAP = GAP_CYCLES;
`else
  localparam int EXP_GAP = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic [6:0] data_in;
  logic       send;
  logic       done;
  logic       busy;
  logic [2:0] fifo_count;
  logic [7:0] frames_sent;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_frames;

  spi_tx_feeder #(.DEPTH(DEPTH), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .data_in(data_in), .send(send), .done(done),
    .busy(busy), .fifo_count(fifo_count), .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_send();
    for (int i = 0; i < 50 && send !== 1'b1; i++) tick();
    chk("send_wait", send, 32'd1);
  endtask

  task automatic write_byte(input logic [6:0] d);
    wr_data  = d;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
  endtask

  // Serve one frame: check data, optionally hold REQ, then pulse done.
  task automatic serve(input logic [6:0] exp_d, input int hold, input int done_len,
                       input logic [2:0] exp_cnt);
    wait_send();
    chk("frame_data", data_in, exp_d);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("req_hold_send", send, 32'd1);
      chk("req_hold_data", data_in, exp_d);
    end
    done = 1'b1;
    for (int i = 0; i < done_len; i++) tick();
    exp_frames = exp_frames + 8'd1;
    chk("pop_count", fifo_count, exp_cnt);
    chk("frames_sent", frames_sent, exp_frames);
    chk("send_low_after_done", send, 32'd0);
    done = 1'b0;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_idle;
    int any_send;
    rst = 1'b1; wr_data = 7'd0; wr_valid = 1'b0; done = 1'b0;
    exp_frames = 8'd0;
    tick(); tick();
    chk("rst_send", send, 32'd0);
    chk("rst_data", data_in, 32'd0);
    chk("rst_count", fifo_count, 32'd0);
    chk("rst_frames", frames_sent, 32'd0);
    chk("rst_wr_ready", wr_ready, 32'd1);
    chk("rst_busy", busy, 32'd0);
    rst = 1'b0;
    tick();

    // Single write 0x55: send one cycle after the write.
    write_byte(7'h55);
    chk("t1_count", fifo_count, 32'd1);
    chk("t1_send_pre", send, 32'd0);
    chk("t1_busy", busy, 32'd1);
    tick();
    chk("t1_send", send, 32'd1);
    chk("t1_data", data_in, 32'h55);
    done = 1'b1;
    tick();
    exp_frames = 8'd1;
    chk("t1_send_drop", send, 32'd0);
    chk("t1_frames", frames_sent, 32'd1);
    chk("t1_count_after", fifo_count, 32'd0);
    done = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("t1_empty_send", send, 32'd0);
    chk("t1_empty_busy", busy, 32'd0);

    // Fill 0x01..0x04; the first frame launches while filling.
    for (int i = 1; i <= 4; i++) write_byte(7'(i));
    chk("t2_full_ready", wr_ready, 32'd0);
    chk("t2_full_count", fifo_count, 32'd4);
    chk("t2_send", send, 32'd1);
    chk("t2_data", data_in, 32'h01);
    // Write offered during the pop cycle while full.
    done = 1'b1; wr_data = 7'h05; wr_valid = 1'b1;
    tick();
    exp_frames = exp_frames + 8'd1;
    chk("t3_count_pop", fifo_count, 32'd3);
    chk("t3_ready", wr_ready, 32'd1);
    chk("t3_frames", frames_sent, exp_frames);
    done = 1'b0;
    tick();
    wr_valid = 1'b0;
    chk("t3_count_refill", fifo_count, 32'd4);
    chk("t3_ready_full", wr_ready, 32'd0);
    // Frame 0x02 holds REQ and then keeps done high for 5 cycles.
    serve(7'h02, 3, 5, 3'd3);
    serve(7'h03, 0, 1, 3'd2);
    serve(7'h04, 0, 1, 3'd1);
    serve(7'h05, 0, 1, 3'd0);

    // done already high in IDLE blocks a new frame.
    for (int i = 0; i < 4; i++) tick();
    done = 1'b1;
    write_byte(7'h2A);
    any_send = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (send) any_send = 1;
    end
    chk("t4_blocked", any_send, 32'd0);
    done = 1'b0;
    tick();
    chk("t4_send", send, 32'd1);
    chk("t4_data", data_in, 32'h2A);
    serve(7'h2A, 0, 1, 3'd0);

    // Inter-frame gap measurement.
    for (int i = 0; i < 4; i++) tick();
    write_byte(7'h11);
    write_byte(7'h22);
    wait_send();
    chk("t5_data1", data_in, 32'h11);
    done = 1'b1;
    tick();
    exp_frames = exp_frames + 8'd1;
    chk("t5_count", fifo_count, 32'd1);
    done = 1'b0;
    n_idle = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (send) break;
      n_idle++;
    end
    chk("t5_gap", n_idle - 1, EXP_GAP);
    serve(7'h22, 0, 1, 3'd0);

    // Reset in REQ with 3 bytes queued, colliding with a write.
    for (int i = 0; i < 4; i++) tick();
    write_byte(7'h31);
    write_byte(7'h32);
    write_byte(7'h33);
    chk("t6_send", send, 32'd1);
    chk("t6_count", fifo_count, 32'd3);
    rst = 1'b1; wr_valid = 1'b1; wr_data = 7'h7F;
    tick();
    chk("t6_rst_send", send, 32'd0);
    chk("t6_rst_count", fifo_count, 32'd0);
    chk("t6_rst_frames", frames_sent, 32'd0);
    chk("t6_rst_data", data_in, 32'd0);
    chk("t6_rst_ready", wr_ready, 32'd1);
    rst = 1'b0; wr_valid = 1'b0;
    any_send = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (send) any_send = 1;
    end
    chk("t6_no_resend", any_send, 32'd0);
    chk("t6_busy", busy, 32'd0);

    // frames_sent wraps 255 -> 0.
    exp_frames = 8'd0;
    for (int i = 0; i < 256; i++) begin
      write_byte(7'(i));
      wait_send();
      done = 1'b1;
      tick();
      done = 1'b0;
      tick();
      exp_frames = exp_frames + 8'd1;
      if (i == 254) chk("t7_frames_255", frames_sent, 32'd255);
    end
    chk("t7_frames_wrap", frames_sent, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
